// File: rtl/instr_issue_queue.sv
// In-order instruction buffer between fetch and decode. Holds {instr, pc, fault}
// in a circular buffer; every issue_* output is derived from registered state only.
module instr_issue_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [31:0]              fetch_instr,
    input  logic [31:0]              fetch_pc,
    input  logic                     fetch_fault,
    output logic                     fetch_ready,
    output logic                     issue_valid,
    output logic [31:0]              issue_instr,
    output logic [31:0]              issue_pc,
    output logic                     issue_fault,
    input  logic                     issue_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          enq;
    logic          deq;

    // Pointers carry one extra MSB so equal low bits can mean either empty or full.
    assign count       = wptr - rptr;
    assign empty       = (wptr == rptr);
    assign full        = (count == (AW+1)'(DEPTH));
    assign fetch_ready = !full;
    assign issue_valid = !empty;

    assign enq = fetch_valid && !full && !flush;
    assign deq = !empty && issue_ready && !flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= wptr;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is observed unless a pointer says it is valid.
    always_ff @(posedge CLK) begin
        if (enq) mem[wptr[AW-1:0]] <= '{instr: fetch_instr, pc: fetch_pc, fault: fetch_fault};
    end

    assign head        = mem[rptr[AW-1:0]];
    assign issue_instr = empty ? NOP_INSTR : head.instr;
    assign issue_pc    = empty ? 32'h0     : head.pc;
    assign issue_fault = empty ? 1'b0      : head.fault;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: a reference model decides acceptance,
// expected entries queue on enqueue and are compared while they sit at the head.
module tb_instr_issue_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    logic        CLK = 0;
    logic        nRST = 0;
    logic        flush = 0, fetch_valid = 0, fetch_fault = 0, issue_ready = 0;
    logic [31:0] fetch_instr = '0, fetch_pc = '0;
    logic        fetch_ready, issue_valid, issue_fault, full, empty;
    logic [31:0] issue_instr, issue_pc;
    logic [$clog2(DEPTH):0] count;

    int   errors = 0, checks = 0;
    int   mc = 0;
    ent_t sb[$];

    instr_issue_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_fault(fetch_fault), .fetch_ready(fetch_ready),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
        .issue_fault(issue_fault), .issue_ready(issue_ready),
        .count(count), .full(full), .empty(empty)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk_state();
        chk("count", 32'(count), 32'(mc));
        chk("empty", 32'(empty), 32'(mc == 0));
        chk("full", 32'(full), 32'(mc == DEPTH));
        chk("fetch_ready", 32'(fetch_ready), 32'(mc < DEPTH));
        chk("issue_valid", 32'(issue_valid), 32'(mc > 0));
        if (mc == 0) begin
            chk("nop_instr", issue_instr, NOP);
            chk("nop_pc", issue_pc, 32'h0);
            chk("nop_fault", 32'(issue_fault), 32'h0);
        end else if (sb.size() > 0) begin
            chk("head_instr", issue_instr, sb[0].instr);
            chk("head_pc", issue_pc, sb[0].pc);
            chk("head_fault", 32'(issue_fault), 32'(sb[0].fault));
        end
    endtask

    // Entered at posedge+1; drives one cycle, checks mid-cycle, advances model at the edge.
    task automatic cyc(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic flt, input logic ir, input logic fl);
        logic enq_m, deq_m;
        fetch_valid = fv; fetch_instr = ins; fetch_pc = pc; fetch_fault = flt;
        issue_ready = ir; flush = fl;
        #3;
        chk_state();
        enq_m = fv && (mc < DEPTH) && !fl;
        deq_m = ir && (mc > 0) && !fl;
        @(posedge CLK); #1;
        if (fl) begin
            sb.delete();
            mc = 0;
        end else begin
            if (deq_m) begin void'(sb.pop_front()); mc--; end
            if (enq_m) begin sb.push_back('{ins, pc, flt}); mc++; end
        end
    endtask

    task automatic idle(); cyc(0, 32'h0, 32'h0, 0, 0, 0); endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        chk_state();
        #2 nRST = 1;
        @(posedge CLK); #1;
        idle();

        // fill to full, fifth word refused, then drain in order
        for (int i = 0; i < 4; i++) cyc(1, 32'h0050_0093 + (i << 7), 32'h200 + 4*i, 0, 0, 0);
        cyc(1, 32'hBAD0_0001, 32'h210, 0, 0, 0);
        cyc(1, 32'hBAD0_0002, 32'h210, 0, 1, 0); // full: dequeue only, no enqueue
        for (int i = 0; i < 4; i++) cyc(0, 32'h0, 32'h0, 0, 1, 0);
        idle();

        // steady stream across pointer wrap
        for (int i = 0; i < 10; i++) cyc(1, 32'h0010_0113 + i, 32'h300 + 4*i, 0, 1, 0);
        cyc(0, 32'h0, 32'h0, 0, 1, 0);
        idle();

        // flush with count=3; flush-cycle word must never issue
        for (int i = 0; i < 3; i++) cyc(1, 32'h0020_0193 + i, 32'h400 + 4*i, 0, 0, 0);
        cyc(1, 32'hDEAD_BEEF, 32'h40C, 0, 1, 1);
        cyc(1, 32'h0030_0213, 32'h800, 0, 0, 0);
        cyc(0, 32'h0, 32'h0, 0, 1, 0);
        idle();

        // fault tag rides with its own entry only
        cyc(1, 32'h0040_0293, 32'h0FFC, 0, 0, 0);
        cyc(1, 32'h0000_0000, 32'h1000, 1, 0, 0);
        cyc(1, 32'h0050_0313, 32'h1004, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 32'h0, 0, 1, 0);
        idle();

        // async reset mid-cycle with count=2
        cyc(1, 32'h0060_0393, 32'h500, 0, 0, 0);
        cyc(1, 32'h0070_0413, 32'h504, 0, 0, 0);
        fetch_valid = 0; issue_ready = 0;
        #1 nRST = 0;
        #1;
        sb.delete();
        mc = 0;
        chk_state();
        #1 nRST = 1;
        @(posedge CLK); #1;
        idle();
        cyc(1, 32'h0080_0493, 32'h600, 0, 0, 0);
        cyc(0, 32'h0, 32'h0, 0, 1, 0);
        idle();

        // random traffic with occasional flush
        for (int i = 0; i < 300; i++)
            cyc(logic'($urandom_range(0, 3) != 0), $urandom, 32'h2000 + 4*i,
                logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 2) != 0),
                logic'($urandom_range(0, 31) == 0));
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 32'h0, 32'h0, 0, 1, 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- Small in-order instruction buffer between the fetch stage and the control unit.
- Accepts fetched words, with PC and access-fault tag, from fetch.
- Presents the head entry on the decode side: issue_instr feeds the control unit's instr input, and issue_fault qualifies fault_insn handling.
- Decouples fetch latency from decode stalls; supports a single-cycle flush on redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- NOP_INSTR, 32'h00000013, word driven on issue_instr when the queue is empty or in reset (addi x0,x0,0).

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all entries (branch/jump/trap redirect).
- fetch_valid  input  1  fetch presents a word this cycle.
- fetch_instr  input  32  fetched instruction word.
- fetch_pc  input  32  PC of fetch_instr.
- fetch_fault  input  1  instruction access fault on this fetch.
- fetch_ready  output  1  queue can accept; equals !full.
- issue_valid  output  1  head entry valid; equals !empty.
- issue_instr  output  32  head instruction word; NOP_INSTR when empty.
- issue_pc  output  32  head PC; 0 when empty.
- issue_fault  output  1  head fault tag; 0 when empty.
- issue_ready  input  1  decode consumes head this cycle.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage: DEPTH-entry circular buffer of {instr, pc, fault}.
  - wptr and rptr are $clog2(DEPTH)+1 bits; the extra MSB disambiguates full from empty.
  - Pointers wrap modulo 2*DEPTH.
- Enqueue: occurs when fetch_valid && fetch_ready && !flush. Writes entry[wptr], then wptr+1.
- Dequeue: occurs when issue_valid && issue_ready && !flush. Advances rptr.
- Latency: a word enqueued at edge N is visible on issue_* after edge N. There is no fall-through from fetch_* to issue_*.
- All outputs are driven from registered state only; no combinational path from any input to any output.
- Simultaneous enqueue and dequeue: both occur; count unchanged.
  - When full, fetch_ready=0 even if issue_ready=1 in the same cycle, so no enqueue happens that cycle.
- Empty with fetch_valid=1: the word enqueues. issue_valid stays 0 in that cycle and rises next cycle.
- issue_ready while empty: ignored; no pointer movement, no underflow.
- fetch_valid while full: ignored; the word is not stored and fetch must hold it.
- Flush (synchronous):
  - At the next edge, rptr := wptr and count := 0.
  - Any enqueue or dequeue in the flush cycle is suppressed; the fetch word presented during flush is dropped.
  - From the cycle after the edge: issue_valid=0 and issue_instr=NOP_INSTR.
- Faulted entries are queued and issued like normal entries; issue_fault=1 accompanies the entry. The queue does not interpret it.
- Reset (async, nRST=0):
  - Immediately: wptr=rptr=0, count=0, empty=1, full=0, fetch_ready=1, issue_valid=0, issue_instr=NOP_INSTR, issue_pc=0, issue_fault=0.
  - Reset mid-operation discards all contents.
  - Storage array contents need not be reset.
- Data integrity: entries issue in exact enqueue order, including across pointer wrap-around.

Test Plan:
- Reset then idle -> issue_valid=0, issue_instr=32'h00000013, fetch_ready=1, count=0, empty=1.
- Enqueue 4 words (0x00500093 @pc 0x200 ... @0x20C), issue_ready=0 -> full=1, fetch_ready=0, count=4; a 5th fetch_valid is not stored; then issue_ready=1 for 4 cycles -> words emerge in order with matching PCs, then empty=1.
- Steady stream with fetch_valid=1 and issue_ready=1 every cycle for 10 cycles across wrap -> count holds at 1 after the first cycle; issue_pc increments by 4 each cycle; no loss or duplication.
- Count=3, flush=1 with fetch_valid=1 and issue_ready=1 -> next cycle count=0, issue_instr=NOP, the flush-cycle fetch word never issues; an enqueue one cycle after flush issues correctly.
- Enqueue with fetch_fault=1 at pc 0x1000 -> issue_fault=1, issue_pc=0x1000 for that entry only; the neighbouring entries show issue_fault=0.
- Assert nRST asynchronously mid-cycle with count=2 -> outputs return to reset values before the next edge; after release the queue behaves as empty.
